// File: rtl/chooser_pkg.sv
// rtl/chooser_pkg.sv - shared FSM state type and counter reset value for the chooser PHT
package chooser_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } chooser_state_e;

    localparam int CTR_RST_VAL = 0;

endpackage

// File: rtl/chooser_sat_ctr.sv
// rtl/chooser_sat_ctr.sv - combinational saturating next-value for one chooser counter
module chooser_sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             p1_correct,
    input  logic             p2_correct,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    // Only a disagreement between the predictors trains the chooser.
    always_comb begin
        ctr_next = ctr;
        if (p2_correct && !p1_correct && ctr != CTR_MAX) begin
            ctr_next = ctr + CTR_W'(1);
        end else if (p1_correct && !p2_correct && ctr != '0) begin
            ctr_next = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/chooser_pht.sv
// rtl/chooser_pht.sv - tournament chooser table with init sweep; CHOOSER_GHR_HASH_EN adds history hashing
module chooser_pht
    import chooser_pkg::*;
#(
    parameter int IDX_W  = 12,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             choice_o,
    output logic [IDX_W-1:0] lookup_hidx_o,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             p1_correct,
    input  logic             p2_correct,
    input  logic             resolved_taken,
    output logic             ready_o
);

    localparam int DEPTH = 1 << IDX_W;

    chooser_state_e   state_q;
    chooser_state_e   state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [CTR_W-1:0] table_q [DEPTH];
    logic [IDX_W-1:0] eff_idx;
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_next;
    logic             sweep_en;
    logic             sweep_last;
    logic             upd_acc;
    logic             bypass;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == ST_RUN);
        sweep_en   = (state_q == ST_INIT);
        sweep_last = sweep_en && (ptr_q == {IDX_W{1'b1}});
        upd_acc    = update_valid && ready_o;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (sweep_en) begin
            ptr_q <= ptr_q + IDX_W'(1);
        end
    end

`ifdef CHOOSER_GHR_HASH_EN
    logic [HIST_W-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (upd_acc) begin
            hist_q <= (hist_q << 1) | HIST_W'(resolved_taken);
        end
    end

    assign eff_idx = lookup_idx ^ IDX_W'(hist_q);
`else
    logic unused_taken;

    assign unused_taken = resolved_taken;
    assign eff_idx      = lookup_idx;
`endif

    assign upd_cur = table_q[update_idx];

    chooser_sat_ctr #(
        .CTR_W (CTR_W)
    ) u_sat_ctr (
        .ctr        (upd_cur),
        .p1_correct (p1_correct),
        .p2_correct (p2_correct),
        .ctr_next   (upd_next)
    );

    // Table has no reset of its own: the INIT sweep is the only thing that gives it a value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (sweep_en) begin
                table_q[ptr_q] <= CTR_W'(CTR_RST_VAL);
            end else if (upd_acc) begin
                table_q[update_idx] <= upd_next;
            end
        end
    end

    assign bypass = upd_acc && (update_idx == eff_idx);

    always_ff @(posedge clk) begin
        if (!rst_n || !ready_o) begin
            choice_o      <= 1'b0;
            lookup_hidx_o <= '0;
        end else begin
            choice_o      <= bypass ? upd_next[CTR_W-1] : table_q[eff_idx][CTR_W-1];
            lookup_hidx_o <= eff_idx;
        end
    end

endmodule
